// File: rtl/udp_pack_pkg.sv
// Shared types and constants for the UDP frame packer.
// Header insertion is compiled in only when SEQ_HDR_EN is defined.
package udp_pack_pkg;

  localparam int unsigned SEQ_W   = 32;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned HDR_LEN = 4;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    GAP
  } rd_state_e;

  // Big-endian byte select of the sequence number: index 0 is the MSB.
  function automatic logic [BYTE_W-1:0] hdr_byte(input logic [SEQ_W-1:0] seq,
                                                 input logic [1:0]       idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = seq[SEQ_W-1  -: BYTE_W];
      2'd1:    b = seq[SEQ_W-9  -: BYTE_W];
      2'd2:    b = seq[SEQ_W-17 -: BYTE_W];
      default: b = seq[SEQ_W-25 -: BYTE_W];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/udp_frame_packer_if.sv
// Byte-stream input and Ethernet TX output bundle of the UDP frame packer.
interface udp_frame_packer_if;
  import udp_pack_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] data_to_eth;
  logic              valid_to_eth;
  logic [CNT_W-1:0]  counter_to_eth;
  logic              ready_to_eth;
  logic              frame_sent;

  modport slave (
    input  in_data, in_valid, ready_to_eth,
    output in_ready, data_to_eth, valid_to_eth, counter_to_eth, frame_sent
  );

  modport master (
    output in_data, in_valid, ready_to_eth,
    input  in_ready, data_to_eth, valid_to_eth, counter_to_eth, frame_sent
  );
endinterface

// File: rtl/udp_frame_packer_ram.sv
// Two-bank frame store: one write port, one registered read port, addressed {bank, ptr}.
module frame_bank_ram #(
  parameter int unsigned DEPTH = 1000,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic             i_wbank,
  input  logic [PTR_W-1:0] i_wptr,
  input  logic [7:0]       i_wdata,
  input  logic             i_re,
  input  logic             i_rbank,
  input  logic [PTR_W-1:0] i_rptr,
  output logic [7:0]       o_rdata
);

  logic [7:0] r_mem [2][DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wbank][i_wptr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_rbank][i_rptr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/udp_frame_packer.sv
// Ping-pong byte framer for the Ethernet/UDP TX path; one whole frame per packet.
// Define SEQ_HDR_EN to prepend a 4-byte big-endian frame sequence number.
module udp_frame_packer
  import udp_pack_pkg::*;
#(
  parameter int unsigned PAYLOAD_LEN = 1000,
  parameter int unsigned GAP_CYCLES  = 16
) (
  input  logic                clk_125m,
  input  logic                rst,
  udp_frame_packer_if.slave   bus
);

  localparam int unsigned PTR_W  = $clog2(PAYLOAD_LEN);
`ifdef SEQ_HDR_EN
  localparam int unsigned HDR_BYTES = HDR_LEN;
`else
  localparam int unsigned HDR_BYTES = 0;
`endif
  localparam int unsigned FRAME_LEN = PAYLOAD_LEN + HDR_BYTES;
  localparam int unsigned FIDX_W    = CNT_W + 1;
  localparam int unsigned GAP_W     = $clog2(GAP_CYCLES + 1);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic              r_wr_bank;
  logic [1:0]        r_full;
  logic              r_in_ready;
  logic              w_wr_en;
  logic              w_wr_last;
  logic              w_wr_bank_nxt;
  logic [1:0]        w_full_nxt;

  rd_state_e         r_state;
  rd_state_e         w_state_nxt;
  logic              r_rd_bank;
  logic [FIDX_W-1:0] r_fidx;
  logic [CNT_W-1:0]  r_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_out_valid;
  logic [7:0]        r_out_data;
  logic              r_skid_valid;
  logic [7:0]        r_skid_data;
  logic              r_pend_valid;
  logic              r_pend_hdr;
  logic [7:0]        r_pend_hdr_byte;

  logic              w_xfer;
  logic              w_rd_last;
  logic              w_active;
  logic [1:0]        w_occ;
  logic              w_fetch;
  logic              w_fetch_hdr;
  logic              w_ram_re;
  logic [PTR_W-1:0]  w_ram_ptr;
  logic [7:0]        w_ram_rdata;
  logic [7:0]        w_hdr_byte;
  logic [7:0]        w_pend_data;

  // ---------------- write side ----------------
  assign w_wr_en       = bus.in_valid && r_in_ready;
  assign w_wr_last     = w_wr_en && (r_wr_ptr == PTR_W'(PAYLOAD_LEN - 1));
  assign w_wr_bank_nxt = r_wr_bank ^ w_wr_last;

  // Full-set and full-clear always land on different banks.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_last) w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk_125m or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_wr_bank  <= 1'b0;
      r_full     <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_full     <= w_full_nxt;
      r_wr_bank  <= w_wr_bank_nxt;
      r_in_ready <= !w_full_nxt[w_wr_bank_nxt];
      if (w_wr_en) r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + 1'b1;
    end
  end

  // ---------------- read side ----------------
  assign w_xfer    = r_out_valid && bus.ready_to_eth;
  assign w_rd_last = w_xfer && (r_cnt == CNT_W'(FRAME_LEN - 1));
  assign w_active  = ((r_state == IDLE) && r_full[r_rd_bank]) ||
                     (r_state == HDR) || (r_state == PAYLOAD);
  assign w_occ     = 2'(r_out_valid) + 2'(r_skid_valid) + 2'(r_pend_valid);

  // Fetch only if out+skid can absorb the byte even if the next cycle stalls.
  assign w_fetch   = w_active && (r_fidx < FIDX_W'(FRAME_LEN)) &&
                     (w_occ <= (2'(w_xfer) + 2'd1));

`ifdef SEQ_HDR_EN
  logic [SEQ_W-1:0] r_seq;

  always_ff @(posedge clk_125m or posedge rst) begin
    if (rst)            r_seq <= '0;
    else if (w_rd_last) r_seq <= r_seq + 1'b1;
  end

  assign w_fetch_hdr = w_fetch && (r_fidx < FIDX_W'(HDR_LEN));
  assign w_hdr_byte  = hdr_byte(r_seq, r_fidx[1:0]);
`else
  assign w_fetch_hdr = 1'b0;
  assign w_hdr_byte  = '0;
`endif

  assign w_ram_re    = w_fetch && !w_fetch_hdr;
  assign w_ram_ptr   = PTR_W'(r_fidx - FIDX_W'(HDR_BYTES));
  assign w_pend_data = r_pend_hdr ? r_pend_hdr_byte : w_ram_rdata;

  frame_bank_ram #(
    .DEPTH (PAYLOAD_LEN),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (clk_125m),
    .i_we    (w_wr_en),
    .i_wbank (r_wr_bank),
    .i_wptr  (r_wr_ptr),
    .i_wdata (bus.in_data),
    .i_re    (w_ram_re),
    .i_rbank (r_rd_bank),
    .i_rptr  (w_ram_ptr),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (r_full[r_rd_bank]) begin
`ifdef SEQ_HDR_EN
          w_state_nxt = HDR;
`else
          w_state_nxt = PAYLOAD;
`endif
        end
      end
      HDR:     if (w_xfer && (r_cnt == CNT_W'(HDR_LEN - 1))) w_state_nxt = PAYLOAD;
      PAYLOAD: if (w_rd_last) w_state_nxt = GAP;
      GAP:     if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_125m or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Frame bookkeeping: bank, fetch index, transfer counter, gap timer.
  always_ff @(posedge clk_125m or posedge rst) begin
    if (rst) begin
      r_rd_bank <= 1'b0;
      r_fidx    <= '0;
      r_cnt     <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_rd_bank <= r_rd_bank ^ w_rd_last;
      if (w_rd_last)    r_fidx <= '0;
      else if (w_fetch) r_fidx <= r_fidx + 1'b1;
      if (w_xfer)       r_cnt  <= w_rd_last ? '0 : r_cnt + 1'b1;
      r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + 1'b1 : '0;
    end
  end

  // Pending (RAM/header) stage feeding the output register and skid slot.
  always_ff @(posedge clk_125m or posedge rst) begin
    if (rst) begin
      r_pend_valid    <= 1'b0;
      r_pend_hdr      <= 1'b0;
      r_pend_hdr_byte <= '0;
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
      r_skid_valid    <= 1'b0;
      r_skid_data     <= '0;
    end else begin
      r_pend_valid <= w_fetch;
      r_pend_hdr   <= w_fetch_hdr;
      if (w_fetch_hdr) r_pend_hdr_byte <= w_hdr_byte;
      if (w_xfer) begin
        if (r_skid_valid) begin
          r_out_data   <= r_skid_data;
          r_skid_valid <= r_pend_valid;
          if (r_pend_valid) r_skid_data <= w_pend_data;
        end else begin
          r_out_valid <= r_pend_valid;
          if (r_pend_valid) r_out_data <= w_pend_data;
        end
      end else if (r_pend_valid) begin
        if (!r_out_valid) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_pend_data;
        end else begin
          r_skid_valid <= 1'b1;
          r_skid_data  <= w_pend_data;
        end
      end
    end
  end

  assign bus.in_ready       = r_in_ready;
  assign bus.valid_to_eth   = r_out_valid;
  assign bus.data_to_eth    = r_out_data;
  assign bus.counter_to_eth = r_cnt;
  assign bus.frame_sent     = w_rd_last;

endmodule
